// File: rtl/ct_rtu_compress_32_seq_pkg.sv
// Shared constants for the RTU bitmap-to-index drain path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ct_rtu_compress_32_seq_pkg;

  // Index width and the entry mask width it addresses.
  localparam int PTR_W     = 5;
  localparam int ENTRY_NUM = 32;

  // Popcount of a 32-bit mask needs 6 bits to represent 32.
  localparam int CNT_W     = 6;

  // Drain controller state encoding.
  typedef enum logic {
    RTU_CMP_IDLE  = 1'b0,
    RTU_CMP_DRAIN = 1'b1
  } rtu_cmp_state_e;

endpackage

// File: rtl/ct_rtu_encode_32.sv
// One-hot 32-bit to 5-bit binary index encoder (OR-tree per output bit).
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input. Zero input encodes to 0.
module ct_rtu_encode_32
  import ct_rtu_compress_32_seq_pkg::*;
(
  input  logic [ENTRY_NUM-1:0] onehot,
  output logic [PTR_W-1:0]     num
);

  // Each index bit is the OR of all one-hot positions whose index has that bit set.
  always_comb begin
    num = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (onehot[i]) begin
        num = num | PTR_W'(i);
      end
    end
  end

endmodule

// File: rtl/ct_rtu_compress_32_seq.sv
// Drains a 32-bit entry mask into one 5-bit index per cycle, lowest index first.
// Latency: first index valid one cycle after the mask is accepted; N set bits take N cycles.
// Backpressure: x_out_rdy low holds every output stable; a new mask is accepted only while idle.
module ct_rtu_compress_32_seq
  import ct_rtu_compress_32_seq_pkg::*;
(
  input  logic                 forever_cpuclk,
  input  logic                 cpurst,
  input  logic                 x_flush,
  input  logic                 x_in_vld,
  output logic                 x_in_rdy,
  input  logic [ENTRY_NUM-1:0] x_in_mask,
  output logic                 x_out_vld,
  input  logic                 x_out_rdy,
  output logic [PTR_W-1:0]     x_out_num,
  output logic [ENTRY_NUM-1:0] x_out_onehot,
  output logic                 x_out_last,
  output logic [CNT_W-1:0]     x_out_cnt,
  output logic                 x_busy
);

  rtu_cmp_state_e       state;
  logic [ENTRY_NUM-1:0] mask_reg;
  logic [ENTRY_NUM-1:0] low_onehot;
  logic [PTR_W-1:0]     low_num;
  logic [CNT_W-1:0]     remain_cnt;
  logic                 remain_last;

  // Isolate the lowest remaining set bit; mask_reg is zero while idle so this is zero too.
  assign low_onehot = mask_reg & (~mask_reg + ENTRY_NUM'(1));

  ct_rtu_encode_32 u_encode (
    .onehot (low_onehot),
    .num    (low_num)
  );

  // Count set bits still pending, the current one included.
  always_comb begin
    remain_cnt = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      remain_cnt = remain_cnt + CNT_W'(mask_reg[i]);
    end
  end

  assign remain_last = (remain_cnt == CNT_W'(1));

  // Controller: reset and flush dominate, then load in idle or retire one bit per accepted index.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state    <= RTU_CMP_IDLE;
      mask_reg <= '0;
    end else if (x_flush) begin
      state    <= RTU_CMP_IDLE;
      mask_reg <= '0;
    end else begin
      case (state)
        RTU_CMP_IDLE: begin
          // An all-zero mask completes the handshake but has nothing to drain.
          if (x_in_vld && (x_in_mask != '0)) begin
            mask_reg <= x_in_mask;
            state    <= RTU_CMP_DRAIN;
          end
        end
        RTU_CMP_DRAIN: begin
          if (x_out_rdy) begin
            mask_reg <= mask_reg & ~low_onehot;
            if (remain_last) begin
              state <= RTU_CMP_IDLE;
            end
          end
        end
        default: begin
          state    <= RTU_CMP_IDLE;
          mask_reg <= '0;
        end
      endcase
    end
  end

  // Outputs decode only registered state, so x_out_rdy never reaches them combinationally.
  assign x_in_rdy     = (state == RTU_CMP_IDLE);
  assign x_busy       = (state == RTU_CMP_DRAIN);
  assign x_out_vld    = (state == RTU_CMP_DRAIN);
  assign x_out_onehot = low_onehot;
  assign x_out_num    = low_num;
  assign x_out_cnt    = remain_cnt;
  assign x_out_last   = remain_last;

  a_onehot_when_vld: assert property (@(posedge forever_cpuclk) disable iff (cpurst)
    x_out_vld |-> $onehot(x_out_onehot));

  a_vld_needs_mask: assert property (@(posedge forever_cpuclk) disable iff (cpurst)
    x_out_vld |-> (mask_reg != '0));

  a_rdy_busy_excl: assert property (@(posedge forever_cpuclk) disable iff (cpurst)
    !(x_in_rdy && x_busy));

endmodule

// File: doc/ct_rtu_compress_32_seq.md
Name: ct_rtu_compress_32_seq

Overview:
- Sequential one-hot/bitmap-to-index drainer for the retire unit.
- Accepts a 32-bit entry mask, e.g. a set of ROB/PST entries to release or flush.
- Emits the 5-bit index of each set bit, one per cycle, lowest index first, over a valid/ready handshake.
- Serves as the binary-encode counterpart of the unit's 5-to-32 entry expansion path; consumers get both the index and the isolated one-hot bit.

Parameters:
- PTR_W, 5, index width; fixed at 5 for this block.
- ENTRY_NUM, 32, mask width; must equal 2**PTR_W.

Ports:
- forever_cpuclk  in   1   clock
- cpurst          in   1   reset, synchronous, active-high
- x_flush         in   1   synchronous abort of current drain
- x_in_vld        in   1   input mask valid
- x_in_rdy        out  1   block can accept a mask
- x_in_mask       in   32  entry bitmap to drain
- x_out_vld       out  1   index valid
- x_out_rdy       in   1   consumer accepts index
- x_out_num       out  5   index of lowest remaining set bit
- x_out_onehot    out  32  isolated lowest remaining set bit
- x_out_last      out  1   current index is the final one of this mask
- x_out_cnt       out  6   number of set bits remaining, including current (1..32)
- x_busy          out  1   state is DRAIN

Behaviour:
- Reset: state IDLE, mask_reg=0. x_out_vld=0, x_out_num=0, x_out_onehot=0, x_out_last=0, x_out_cnt=0, x_busy=0, x_in_rdy=1.
- States: IDLE, DRAIN. 1-bit state register.
- x_in_rdy = (state==IDLE). No overlap of masks; one bubble cycle between consecutive masks.
- IDLE, x_in_vld=1, x_in_mask!=0: mask_reg<=x_in_mask; go DRAIN. First x_out_vld is the next cycle (latency 1).
- IDLE, x_in_vld=1, x_in_mask==0: handshake completes, mask discarded, stay IDLE, no output.
- DRAIN:
  - x_out_vld=1.
  - x_out_onehot = mask_reg & (~mask_reg+1).
  - x_out_num = binary encode of x_out_onehot.
  - x_out_cnt = popcount(mask_reg).
  - x_out_last = (x_out_cnt==1).
  - All outputs derive only from registered state; no combinational path from x_out_rdy.
- DRAIN, x_out_rdy=1: mask_reg<=mask_reg & ~x_out_onehot. If x_out_last, go IDLE (mask_reg becomes 0).
- DRAIN, x_out_rdy=0: hold all outputs stable (AXI-style valid stability).
- Throughput: one index per cycle under continuous x_out_rdy. A mask with N set bits completes in N cycles after the load cycle.
- x_flush:
  - Highest priority in any state: next cycle state=IDLE, mask_reg=0.
  - Any output handshake in the flush cycle is still reported to the consumer but its effect is discarded.
  - x_in_vld in a flush cycle is ignored: x_in_rdy is still driven per state, but no load occurs. The upstream must not treat it as accepted; flush qualifies the handshake.
- cpurst mid-drain: identical to flush plus all outputs to reset values next cycle.
- Boundary values:
  - mask=32'h8000_0000 gives a single output num=31, last=1, cnt=1.
  - mask=32'hFFFF_FFFF gives cnt=32 (6-bit width required), then 31, ..., 1.
- Assertions: x_out_onehot is one-hot when x_out_vld; x_out_vld implies mask_reg!=0; x_in_rdy and x_busy are mutually exclusive.

Decomposition:
- Shared package:
  - PTR_W, ENTRY_NUM.
  - State encoding constants RTU_CMP_IDLE=1'b0, RTU_CMP_DRAIN=1'b1.
  - 32-bit popcount width constant CNT_W=6.
- One natural sub-module: ct_rtu_encode_32, a purely combinational 32-bit one-hot to 5-bit binary encoder (OR-tree per output bit). Reused by other RTU pointer logic.
- Popcount stays inline.

Test Plan:
- Load mask 32'h0000_0015, x_out_rdy=1 always.
  - Outputs on cycles N+1..N+3: num=0,2,4; cnt=3,2,1; last only on num=4.
  - x_in_rdy=1 again at N+4.
- Load 32'hFFFF_FFFF with x_out_rdy=1: 32 consecutive outputs num=0..31, cnt 32 down to 1, onehot=1<<num.
- Load 32'h8000_0001, hold x_out_rdy=0 for 3 cycles: num=0, onehot=1, cnt=2 stable for all 3 cycles; then release gives num=31, last=1.
- Load 32'h0000_00F0, assert x_flush with x_out_rdy=1 while num=5 is shown.
  - Next cycle: x_out_vld=0, x_in_rdy=1, x_busy=0.
  - New mask 32'h2 then yields num=1.
- x_in_vld with mask 32'h0: x_in_rdy stays 1, x_out_vld never asserts, state stays IDLE.
- cpurst asserted mid-drain of 32'h0000_0F00 after num=8: next cycle all outputs are at reset values; a following load of 32'h4 yields num=2.
